// File: rtl/count_window_meter.sv
// Window meter for a free-running event counter: per-window modulo delta on a
// valid/ready slot, saturating total, stall flag. Optional peak tracker: COUNT_WINDOW_METER_PEAK_EN.
module count_window_meter #(
    parameter int WIDTH       = 8,
    parameter int WIN_CYCLES  = 16,
    parameter int TOT_WIDTH   = 16,
    parameter int STALL_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     count_in,
    input  logic                 enable,
    output logic [WIDTH-1:0]     delta,
    output logic                 delta_valid,
    input  logic                 delta_ready,
    output logic [TOT_WIDTH-1:0] total,
    output logic                 stalled,
    output logic                 overrun,
`ifdef COUNT_WINDOW_METER_PEAK_EN
    input  logic                 peak_clr,
    output logic [WIDTH-1:0]     peak,
`endif
    output logic                 state_o
);

    localparam int CW = (WIN_CYCLES > 2) ? $clog2(WIN_CYCLES) : 1;
    localparam int SW = $clog2(STALL_LIMIT + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [WIDTH-1:0]     base_q, base_d;
    logic [CW-1:0]        win_cnt_q, win_cnt_d;
    logic [WIDTH-1:0]     delta_q, delta_d;
    logic                 delta_valid_q, delta_valid_d;
    logic [TOT_WIDTH-1:0] total_q, total_d;
    logic [SW-1:0]        stall_cnt_q, stall_cnt_d;
    logic                 stalled_q, stalled_d;
    logic                 overrun_q, overrun_d;

    logic                 win_end;
    logic                 xfer;
    logic [WIDTH-1:0]     win_delta;
    logic [TOT_WIDTH:0]   total_sum;
    logic [TOT_WIDTH-1:0] total_sat;

    // Output slot handshake: delta is offered while delta_valid is high and
    // leaves the slot on any cycle with delta_valid && delta_ready; a new
    // window result may be written in that same cycle.
    assign xfer      = delta_valid_q && delta_ready;
    assign win_end   = (state_q == S_RUN) && enable && (win_cnt_q == CW'(WIN_CYCLES - 1));
    assign win_delta = count_in - base_q;

    // Modulo subtraction above already handles counter wrap; total only needs saturation.
    assign total_sum = {1'b0, total_q} + {{(TOT_WIDTH + 1 - WIDTH){1'b0}}, win_delta};
    assign total_sat = total_sum[TOT_WIDTH] ? {TOT_WIDTH{1'b1}} : total_sum[TOT_WIDTH-1:0];

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        win_cnt_d     = win_cnt_q;
        delta_d       = delta_q;
        delta_valid_d = delta_valid_q;
        total_d       = total_q;
        stall_cnt_d   = stall_cnt_q;
        overrun_d     = overrun_q;

        if (xfer) begin
            delta_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d   = S_RUN;
                    base_d    = count_in;
                    win_cnt_d = '0;
                end
            end
            S_RUN: begin
                if (!enable) begin
                    state_d     = S_IDLE;
                    win_cnt_d   = '0;
                    stall_cnt_d = '0;
                end else if (win_end) begin
                    base_d    = count_in;
                    win_cnt_d = '0;
                    total_d   = total_sat;
                    if (win_delta == '0) begin
                        if (stall_cnt_q != SW'(STALL_LIMIT)) begin
                            stall_cnt_d = stall_cnt_q + SW'(1);
                        end
                    end else begin
                        stall_cnt_d = '0;
                    end
                    if (!delta_valid_q || delta_ready) begin
                        delta_d       = win_delta;
                        delta_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else begin
                    win_cnt_d = win_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        stalled_d = (stall_cnt_d == SW'(STALL_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            base_q        <= '0;
            win_cnt_q     <= '0;
            delta_q       <= '0;
            delta_valid_q <= 1'b0;
            total_q       <= '0;
            stall_cnt_q   <= '0;
            stalled_q     <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            win_cnt_q     <= win_cnt_d;
            delta_q       <= delta_d;
            delta_valid_q <= delta_valid_d;
            total_q       <= total_d;
            stall_cnt_q   <= stall_cnt_d;
            stalled_q     <= stalled_d;
            overrun_q     <= overrun_d;
        end
    end

`ifdef COUNT_WINDOW_METER_PEAK_EN
    logic [WIDTH-1:0] peak_q, peak_d;

    // A clear coinciding with a window end restarts the peak from that window.
    always_comb begin
        peak_d = peak_q;
        if (peak_clr) begin
            peak_d = win_end ? win_delta : '0;
        end else if (win_end && (win_delta > peak_q)) begin
            peak_d = win_delta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak = peak_q;
`endif

    assign delta       = delta_q;
    assign delta_valid = delta_valid_q;
    assign total       = total_q;
    assign stalled     = stalled_q;
    assign overrun     = overrun_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_count_window_meter.sv
// Bench for count_window_meter: directed scenarios plus randomized traffic
// against a window-level reference model; a second instance uses an 8-bit total.
module tb_count_window_meter;

    localparam int WIN   = 16;
    localparam int LIMIT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] count_in = 8'd0;
    logic       enable = 1'b0;
    logic       delta_ready = 1'b0;

    logic [7:0]  delta, delta_b;
    logic        delta_valid, delta_valid_b;
    logic [15:0] total;
    logic [7:0]  total_b;
    logic        stalled, stalled_b, overrun, overrun_b, state_o, state_b;
`ifdef COUNT_WINDOW_METER_PEAK_EN
    logic       peak_clr = 1'b0;
    logic [7:0] peak, peak_b;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    // reference model state (window-level view)
    bit m_run, m_full, m_overrun;
    int m_phase, m_base, m_delta, m_total, m_total8, m_zero, m_peak;

    always #5 clk = ~clk;

    count_window_meter #(.WIDTH(8), .WIN_CYCLES(16), .TOT_WIDTH(16), .STALL_LIMIT(4)) dut (
        .clk(clk), .rst(rst), .count_in(count_in), .enable(enable),
        .delta(delta), .delta_valid(delta_valid), .delta_ready(delta_ready),
        .total(total), .stalled(stalled), .overrun(overrun),
`ifdef COUNT_WINDOW_METER_PEAK_EN
        .peak_clr(peak_clr), .peak(peak),
`endif
        .state_o(state_o)
    );

    count_window_meter #(.WIDTH(8), .WIN_CYCLES(16), .TOT_WIDTH(8), .STALL_LIMIT(4)) dut_sat (
        .clk(clk), .rst(rst), .count_in(count_in), .enable(enable),
        .delta(delta_b), .delta_valid(delta_valid_b), .delta_ready(delta_ready),
        .total(total_b), .stalled(stalled_b), .overrun(overrun_b),
`ifdef COUNT_WINDOW_METER_PEAK_EN
        .peak_clr(peak_clr), .peak(peak_b),
`endif
        .state_o(state_b)
    );

    task automatic model_step(input int c, input bit en, input bit rdy, input bit r, input bit pc);
        int d;
        bit xfer, wend, loaded;
        d = 0; wend = 1'b0; loaded = 1'b0;
        if (r) begin
            m_run = 0; m_full = 0; m_overrun = 0;
            m_phase = 0; m_base = 0; m_delta = 0; m_total = 0; m_total8 = 0; m_zero = 0; m_peak = 0;
            return;
        end
        xfer = m_full && rdy;
        if (!m_run) begin
            if (en) begin
                m_run = 1; m_base = c; m_phase = 0;
            end
        end else if (!en) begin
            m_run = 0; m_phase = 0; m_zero = 0;
        end else if (m_phase == WIN - 1) begin
            wend = 1'b1;
            d = (c - m_base + 256) % 256;
            m_base = c; m_phase = 0;
            m_total  = (m_total + d > 65535) ? 65535 : m_total + d;
            m_total8 = (m_total8 + d > 255) ? 255 : m_total8 + d;
            if (d == 0) m_zero = (m_zero < LIMIT) ? m_zero + 1 : LIMIT;
            else m_zero = 0;
            if (!m_full || xfer) begin
                m_delta = d; m_full = 1; loaded = 1'b1;
            end else begin
                m_overrun = 1;
            end
        end else begin
            m_phase++;
        end
        if (xfer && !loaded) m_full = 0;
        if (pc) m_peak = wend ? d : 0;
        else if (wend && d > m_peak) m_peak = d;
    endtask

    // Applies one cycle of inputs, advances the model, and returns #1 after the edge.
    task automatic drive(input int c, input bit en, input bit rdy, input bit r, input bit pc);
        count_in    = 8'(c);
        enable      = en;
        delta_ready = rdy;
        rst         = r;
`ifdef COUNT_WINDOW_METER_PEAK_EN
        peak_clr    = pc;
`endif
        model_step(c % 256, en, rdy, r, pc);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
    endtask

    task automatic test_reset();
        drive(8'h55, 1, 1, 1, 0);
        tests_run++;
        if (delta !== 8'd0) begin tests_failed++; $display("FAIL reset_delta: got %0d expected 0", delta); end
        tests_run++;
        if (delta_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", delta_valid); end
        tests_run++;
        if (total !== 16'd0) begin tests_failed++; $display("FAIL reset_total: got %0d expected 0", total); end
        tests_run++;
        if ({stalled, overrun} !== 2'b00) begin tests_failed++; $display("FAIL reset_flags: got %b expected 00", {stalled, overrun}); end
        tests_run++;
        if (state_o !== 1'b0) begin tests_failed++; $display("FAIL reset_state: got %b expected 0 (IDLE)", state_o); end
    endtask

    task automatic test_basic_window();
        int first_valid;
        first_valid = -1;
        do_reset();
        for (int k = 1; k <= 49; k++) begin
            drive(k - 1, 1, 1, 0, 0);
            if (delta_valid === 1'b1 && first_valid < 0) first_valid = k;
            tests_run++;
            if (delta_valid !== ((k - 1) % 16 == 0 && k > 1)) begin
                tests_failed++; $display("FAIL basic_valid k=%0d: got %b expected %b", k, delta_valid, ((k - 1) % 16 == 0 && k > 1));
            end
            if ((k - 1) % 16 == 0 && k > 1) begin
                tests_run++;
                if (delta !== 8'd16) begin tests_failed++; $display("FAIL basic_delta k=%0d: got %0d expected 16", k, delta); end
                tests_run++;
                if (total !== 16'(k - 1)) begin tests_failed++; $display("FAIL basic_total k=%0d: got %0d expected %0d", k, total, k - 1); end
            end
        end
        tests_run++;
        if (first_valid != 17) begin tests_failed++; $display("FAIL basic_latency: got %0d expected 17", first_valid); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 1; k <= 17; k++) drive((249 + k) % 256, 1, 1, 0, 0);
        tests_run++;
        if (delta_valid !== 1'b1 || delta !== 8'd16) begin
            tests_failed++; $display("FAIL wrap_delta: got valid=%b delta=%0d expected valid=1 delta=16", delta_valid, delta);
        end
        tests_run++;
        if (total !== 16'd16) begin tests_failed++; $display("FAIL wrap_total: got %0d expected 16", total); end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 1; k <= 33; k++) begin
            drive(k - 1, 1, 0, 0, 0);
            if (k == 17 || k == 32) begin
                tests_run++;
                if (delta_valid !== 1'b1 || delta !== 8'd16 || overrun !== 1'b0) begin
                    tests_failed++; $display("FAIL bp_hold k=%0d: got valid=%b delta=%0d overrun=%b expected 1/16/0", k, delta_valid, delta, overrun);
                end
            end
        end
        tests_run++;
        if (overrun !== 1'b1) begin tests_failed++; $display("FAIL bp_overrun: got %b expected 1", overrun); end
        tests_run++;
        if (delta !== 8'd16 || delta_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_kept: got valid=%b delta=%0d expected 1/16", delta_valid, delta); end
        tests_run++;
        if (total !== 16'd32) begin tests_failed++; $display("FAIL bp_total: got %0d expected 32", total); end
        drive(33, 1, 1, 0, 0);
        tests_run++;
        if (delta_valid !== 1'b0 || delta !== 8'd16 || overrun !== 1'b1) begin
            tests_failed++; $display("FAIL bp_drain: got valid=%b delta=%0d overrun=%b expected 0/16/1", delta_valid, delta, overrun);
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int k = 1; k <= 65; k++) begin
            drive(7, 1, 1, 0, 0);
            if (k == 49) begin
                tests_run++;
                if (stalled !== 1'b0 || delta_valid !== 1'b1 || delta !== 8'd0) begin
                    tests_failed++; $display("FAIL stall_w3: got stalled=%b valid=%b delta=%0d expected 0/1/0", stalled, delta_valid, delta);
                end
            end
        end
        tests_run++;
        if (stalled !== 1'b1 || delta !== 8'd0) begin tests_failed++; $display("FAIL stall_set: got stalled=%b delta=%0d expected 1/0", stalled, delta); end
        for (int k = 66; k <= 81; k++) begin
            drive(k - 58, 1, 1, 0, 0);
            if (k == 80) begin
                tests_run++;
                if (stalled !== 1'b1) begin tests_failed++; $display("FAIL stall_hold: got %b expected 1", stalled); end
            end
        end
        tests_run++;
        if (stalled !== 1'b0 || delta !== 8'd16 || delta_valid !== 1'b1) begin
            tests_failed++; $display("FAIL stall_clear: got stalled=%b delta=%0d valid=%b expected 0/16/1", stalled, delta, delta_valid);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 1; k <= 273; k++) begin
            drive((k - 1) % 256, 1, 1, 0, 0);
            if (k == 241 || k == 257 || k == 273) begin
                tests_run++;
                if (total_b !== ((k == 241) ? 8'd240 : 8'd255)) begin
                    tests_failed++; $display("FAIL sat_total k=%0d: got %0d expected %0d", k, total_b, (k == 241) ? 240 : 255);
                end
            end
        end
        tests_run++;
        if (total !== 16'd272) begin tests_failed++; $display("FAIL sat_wide_total: got %0d expected 272", total); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 1; k <= 26; k++) drive(k - 1, 1, 0, 0, 0);
        tests_run++;
        if (delta_valid !== 1'b1) begin tests_failed++; $display("FAIL rmid_pre: got valid=%b expected 1", delta_valid); end
        drive(26, 1, 1, 1, 0);
        tests_run++;
        if ({delta, delta_valid, total, stalled, overrun, state_o} !== 28'd0) begin
            tests_failed++; $display("FAIL rmid_clear: got delta=%0d valid=%b total=%0d stalled=%b overrun=%b state=%b expected all 0",
                                     delta, delta_valid, total, stalled, overrun, state_o);
        end
    endtask

    task automatic test_enable_drop();
        do_reset();
        for (int k = 1; k <= 10; k++) drive(k - 1, 1, 1, 0, 0);
        for (int k = 11; k <= 14; k++) begin
            drive(k - 1, 0, 1, 0, 0);
            tests_run++;
            if (state_o !== 1'b0 || delta_valid !== 1'b0) begin
                tests_failed++; $display("FAIL edrop_idle k=%0d: got state=%b valid=%b expected 0/0", k, state_o, delta_valid);
            end
        end
        for (int k = 15; k <= 46; k++) begin
            drive(k - 1, 1, 1, 0, 0);
            if (k <= 30) begin
                tests_run++;
                if (delta_valid !== 1'b0) begin tests_failed++; $display("FAIL edrop_early k=%0d: got valid=%b expected 0", k, delta_valid); end
            end else if (k == 31) begin
                tests_run++;
                if (delta_valid !== 1'b1 || delta !== 8'd16) begin
                    tests_failed++; $display("FAIL edrop_fresh: got valid=%b delta=%0d expected 1/16", delta_valid, delta);
                end
            end
        end
        // enable falls exactly on the window-end cycle
        drive(46, 0, 1, 0, 0);
        tests_run++;
        if (delta_valid !== 1'b0 || total !== 16'd16 || state_o !== 1'b0) begin
            tests_failed++; $display("FAIL edrop_winend: got valid=%b total=%0d state=%b expected 0/16/0", delta_valid, total, state_o);
        end
    endtask

    task automatic test_random();
        int  cnt;
        bit  frozen, en, r, rdy, pc;
        cnt = $urandom_range(0, 255);
        frozen = 1'b0;
        en = 1'b1;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 149) == 0) frozen = ~frozen;
            if (!frozen) cnt = (cnt + $urandom_range(0, 3)) % 256;
            if (en) en = ($urandom_range(0, 79) != 0);
            else en = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            r   = ($urandom_range(0, 699) == 0);
            pc  = ($urandom_range(0, 29) == 0);
            drive(cnt, en, rdy, r, pc);
            tests_run++;
            if (delta_valid !== m_full || delta !== 8'(m_delta)) begin
                tests_failed++; $display("FAIL rnd_slot i=%0d: got valid=%b delta=%0d expected %b/%0d", i, delta_valid, delta, m_full, m_delta);
            end
            tests_run++;
            if (total !== 16'(m_total) || total_b !== 8'(m_total8)) begin
                tests_failed++; $display("FAIL rnd_total i=%0d: got %0d/%0d expected %0d/%0d", i, total, total_b, m_total, m_total8);
            end
            tests_run++;
            if (stalled !== (m_zero == LIMIT) || overrun !== m_overrun || state_o !== m_run) begin
                tests_failed++; $display("FAIL rnd_flags i=%0d: got stalled=%b overrun=%b state=%b expected %b/%b/%b",
                                         i, stalled, overrun, state_o, (m_zero == LIMIT), m_overrun, m_run);
            end
`ifdef COUNT_WINDOW_METER_PEAK_EN
            tests_run++;
            if (peak !== 8'(m_peak)) begin tests_failed++; $display("FAIL rnd_peak i=%0d: got %0d expected %0d", i, peak, m_peak); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic_window();
        test_wrap();
        test_backpressure();
        test_stall();
        test_saturation();
        test_reset_mid();
        test_enable_drop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/count_window_meter.md
Name: count_window_meter

Overview:
- Downstream consumer of a free-running multi-bit event counter produced by a register stage in the same clock domain (e.g. the per-domain count outputs of a multi-clock counter block).
- Samples the counter every WIN_CYCLES cycles and computes the modulo-2^WIDTH delta per window.
- Hands each delta out over a valid/ready port, and keeps a saturating running total plus a stall flag.
- Instantiated once per clock domain, next to the counter it observes.

Parameters:
WIDTH, 8, width of count_in and delta
WIN_CYCLES, 16, window length in cycles (>=2)
TOT_WIDTH, 16, width of saturating total (>=WIDTH)
STALL_LIMIT, 4, consecutive zero-delta windows before stalled asserts (>=1)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
count_in  input  WIDTH  free-running counter, synchronous to clk
enable  input  1  run measurement
delta  output  WIDTH  window delta (registered)
delta_valid  output  1  delta holds an unconsumed value
delta_ready  input  1  consumer accepts delta
total  output  TOT_WIDTH  saturating sum of all window deltas
stalled  output  1  STALL_LIMIT consecutive zero deltas seen
overrun  output  1  sticky: a delta was dropped

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset: every register is cleared. State=IDLE, base=0, win_cnt=0. Outputs: delta=0, delta_valid=0, total=0, stalled=0, overrun=0. rst wins over every other input in the same cycle.
- States: IDLE, RUN.
- IDLE: if enable=1, then base<=count_in, win_cnt<=0, and go to RUN.
- RUN, enable=0: go to IDLE.
  - win_cnt<=0 and stall_cnt<=0; stalled is cleared.
  - A pending delta/delta_valid is kept until it is consumed.
- RUN, enable=1: win_cnt increments each cycle.
- Window end: RUN, enable=1, win_cnt==WIN_CYCLES-1. Then:
  - d=(count_in-base) mod 2^WIDTH, so wrap-around is handled naturally. base<=count_in and win_cnt<=0.
  - The first window's sample is therefore taken exactly WIN_CYCLES cycles after the base capture.
  - Windows are back-to-back with no gap cycle.
- Output slot: a single register.
  - A transfer occurs when delta_valid&&delta_ready.
  - At window end, if the slot is empty or transferring in the same cycle: delta<=d and delta_valid<=1, visible the cycle after window end.
  - Otherwise d is dropped and overrun<=1. overrun is sticky until rst.
  - A transfer with no new load gives delta_valid<=0; delta keeps its last value.
- total: at every window end (including a dropped one), total<=min(total+zext(d), 2^TOT_WIDTH-1).
- Stall counting, at each window end:
  - If d==0: stall_cnt increments, saturating at STALL_LIMIT.
  - Otherwise stall_cnt<=0.
  - stalled = (stall_cnt==STALL_LIMIT), registered.
- Simultaneous window end and enable falling: enable=0 takes priority, so no sample is taken.

Optional Feature:
COUNT_WINDOW_METER_PEAK_EN:
- Defined: adds input peak_clr (1) and output peak (WIDTH, reset 0).
  - At each window end, peak<=max(peak,d).
  - peak_clr=1 sets peak<=0. If it coincides with a window end, peak<=d.
- Undefined: both ports and the peak register are absent; behaviour is otherwise identical.

Test Plan:
- Basic window: defaults, count_in+1 per cycle starting at 0, enable held 1, delta_ready=1. Required: a delta=16 pulse every 16 cycles, first delta_valid 17 cycles after enable is first seen; total=16,32,48...
- Wrap-around: count_in starts at 250, +1 per cycle. Required: first delta=16 (250->10); total=16.
- Backpressure: delta_ready=0 across two window ends. Required: first delta is held with delta_valid=1; second is dropped with overrun=1 one cycle after the second window end; total still adds both (32).
- Stall: count_in constant at 7 for 4 windows. Required: delta=0 four times; stalled=1 the cycle after the 4th window end; the next window with count_in +1/cycle gives delta=16 and stalled=0.
- Saturation: TOT_WIDTH=8, +1 per cycle for 17 windows. Required: total=240 after 15 windows; 255 after the 16th and stays 255.
- Reset mid-window and enable drop: assert rst at win_cnt=9 with delta_valid=1. Required: all outputs 0 the next cycle, state IDLE. Separately, enable=0 at win_cnt=9 gives no delta; re-enable gives a fresh 16-cycle window.
